// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
// The watchdog constants are used only when SDRAM_ARB_TIMEOUT_EN is defined.
package sdram_arb_pkg;

    localparam int unsigned REQ_ADDR_W = 32;
    localparam int unsigned REQ_DATA_W = 32;
    localparam int unsigned REQ_STRB_W = REQ_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic [REQ_STRB_W-1:0] wstrb;
    } req_t;

    localparam logic [15:0] TIMEOUT_VAL  = 16'hFFFF;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Two-way round-robin picker; a full DMA run forces port 0 to win a tie.
module sdram_arb_rr_pick (
    input  logic [1:0] valids,
    input  logic       last_grant,
    input  logic       dma_run_full,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (valids == 2'b10) begin
            grant = 1'b1;
        end else if (valids == 2'b11) begin
            grant = dma_run_full ? 1'b0 : ~last_grant;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller native port between the CPU bridge (port 0)
// and the SD DMA engine (port 1), one transaction in flight at a time.
// Optional watchdog: define SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_DMA_RUN = 4
) (
    input  logic                    i_sysclk,
    input  logic                    i_rst_n,
    input  logic                    i_p0_valid,
    output logic                    o_p0_ready,
    input  logic                    i_p0_we,
    input  logic [ADDR_WIDTH-1:0]   i_p0_addr,
    input  logic [DATA_WIDTH-1:0]   i_p0_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_p0_wstrb,
    output logic                    o_p0_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_p0_rdata,
    input  logic                    i_p1_valid,
    output logic                    o_p1_ready,
    input  logic                    i_p1_we,
    input  logic [ADDR_WIDTH-1:0]   i_p1_addr,
    input  logic [DATA_WIDTH-1:0]   i_p1_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_p1_wstrb,
    output logic                    o_p1_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_p1_rdata,
`ifdef SDRAM_ARB_TIMEOUT_EN
    output logic                    o_timeout,
`endif
    output logic                    o_mem_valid,
    input  logic                    i_mem_ready,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
    input  logic                    i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned RUN_W  = $clog2(MAX_DMA_RUN + 1);

    state_t                  state_q, state_d;
    req_t                    cmd_q;
    logic                    last_grant_q;
    logic [RUN_W-1:0]        dma_run_q;
    logic                    mem_valid_q;
    logic                    pick;
    logic                    grant_fire;
    logic                    rsp_fire;
    logic                    timeout_fire;
    logic                    dma_run_full;
    logic [DATA_WIDTH-1:0]   rsp_data;

    assign dma_run_full = (dma_run_q == RUN_W'(MAX_DMA_RUN));

    sdram_arb_rr_pick u_pick (
        .valids       ({i_p1_valid, i_p0_valid}),
        .last_grant   (last_grant_q),
        .dma_run_full (dma_run_full),
        .grant        (pick)
    );

    assign grant_fire = (state_q == IDLE) && (i_p0_valid || i_p1_valid);
    assign o_p0_ready = grant_fire && !pick;
    assign o_p1_ready = grant_fire && pick;
    assign rsp_fire   = (state_q == WAIT) && i_mem_rsp_valid;

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic [15:0] wd_q;

    // A genuine completion in the same cycle takes precedence over the watchdog.
    assign timeout_fire = (state_q != IDLE) && (wd_q == TIMEOUT_VAL) && !rsp_fire;

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_q      <= '0;
            o_timeout <= 1'b0;
        end else begin
            wd_q <= (state_q == IDLE) ? 16'd0 : wd_q + 16'd1;
            if (timeout_fire) o_timeout <= 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_fire) state_d = ISSUE;
            ISSUE:   if (timeout_fire) state_d = IDLE;
                     else if (i_mem_ready) state_d = WAIT;
            WAIT:    if (rsp_fire || timeout_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command register, grant pointer and registered mem_valid.
    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_q        <= '0;
            last_grant_q <= 1'b1;
            mem_valid_q  <= 1'b0;
        end else begin
            mem_valid_q <= (state_d == ISSUE);
            if (grant_fire) begin
                last_grant_q <= pick;
                if (pick) begin
                    cmd_q <= '{we: i_p1_we, addr: REQ_ADDR_W'(i_p1_addr),
                               wdata: REQ_DATA_W'(i_p1_wdata), wstrb: REQ_STRB_W'(i_p1_wstrb)};
                end else begin
                    cmd_q <= '{we: i_p0_we, addr: REQ_ADDR_W'(i_p0_addr),
                               wdata: REQ_DATA_W'(i_p0_wdata), wstrb: REQ_STRB_W'(i_p0_wstrb)};
                end
            end
        end
    end

    // Consecutive port-1 grants while port 0 is waiting.
    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dma_run_q <= '0;
        end else if (!i_p0_valid) begin
            dma_run_q <= '0;
        end else if (grant_fire) begin
            if (!pick)              dma_run_q <= '0;
            else if (!dma_run_full) dma_run_q <= dma_run_q + RUN_W'(1);
        end
    end

    assign rsp_data = timeout_fire ? DATA_WIDTH'(TIMEOUT_DATA)
                    : (cmd_q.we ? '0 : i_mem_rdata);

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_p0_rsp_valid <= 1'b0;
            o_p1_rsp_valid <= 1'b0;
            o_p0_rdata     <= '0;
            o_p1_rdata     <= '0;
        end else begin
            o_p0_rsp_valid <= 1'b0;
            o_p1_rsp_valid <= 1'b0;
            o_p0_rdata     <= '0;
            o_p1_rdata     <= '0;
            if (rsp_fire || timeout_fire) begin
                if (last_grant_q) begin
                    o_p1_rsp_valid <= 1'b1;
                    o_p1_rdata     <= rsp_data;
                end else begin
                    o_p0_rsp_valid <= 1'b1;
                    o_p0_rdata     <= rsp_data;
                end
            end
        end
    end

    assign o_mem_valid = mem_valid_q;
    assign o_mem_we    = cmd_q.we;
    assign o_mem_addr  = ADDR_WIDTH'(cmd_q.addr);
    assign o_mem_wdata = DATA_WIDTH'(cmd_q.wdata);
    assign o_mem_wstrb = STRB_W'(cmd_q.wstrb);

    a_rsp_only_in_wait: assert property (
        @(posedge i_sysclk) disable iff (!i_rst_n) i_mem_rsp_valid |-> (state_q == WAIT)
    ) else $error("i_mem_rsp_valid received outside WAIT");

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: a controller model, per-port expected
// response queues and a monitor that checks every response pulse.
module tb_sdram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_valid, p0_ready, p0_we, p0_rsp_valid;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [3:0]  p0_wstrb;
    logic        p1_valid, p1_ready, p1_we, p1_rsp_valid;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p1_wstrb;
    logic        mem_valid, mem_ready, mem_we, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        model_ready, stray_ready, model_rsp, stray_rsp;
    logic [31:0] model_rdata;
`ifdef SDRAM_ARB_TIMEOUT_EN
    logic        timeout;
`endif

    assign mem_ready     = model_ready | stray_ready;
    assign mem_rsp_valid = model_rsp | stray_rsp;
    assign mem_rdata     = model_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    int gnt_log[$];
    int run_len = 0;
    int max_run = 0;
    int ctrl_en = 1;
    int ready_delay = 0;
    int rsp_delay = 3;
    int in_wait = 0;
    int timeout_phase = 0;
    logic        rsp_prev = 1'b0;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;

    sdram_arbiter dut (
        .i_sysclk       (clk),
        .i_rst_n        (rst_n),
        .i_p0_valid     (p0_valid),
        .o_p0_ready     (p0_ready),
        .i_p0_we        (p0_we),
        .i_p0_addr      (p0_addr),
        .i_p0_wdata     (p0_wdata),
        .i_p0_wstrb     (p0_wstrb),
        .o_p0_rsp_valid (p0_rsp_valid),
        .o_p0_rdata     (p0_rdata),
        .i_p1_valid     (p1_valid),
        .o_p1_ready     (p1_ready),
        .i_p1_we        (p1_we),
        .i_p1_addr      (p1_addr),
        .i_p1_wdata     (p1_wdata),
        .i_p1_wstrb     (p1_wstrb),
        .o_p1_rsp_valid (p1_rsp_valid),
        .o_p1_rdata     (p1_rdata),
`ifdef SDRAM_ARB_TIMEOUT_EN
        .o_timeout      (timeout),
`endif
        .o_mem_valid    (mem_valid),
        .i_mem_ready    (mem_ready),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_wstrb    (mem_wstrb),
        .i_mem_rsp_valid(mem_rsp_valid),
        .i_mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rsp_prev <= mem_rsp_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdata_for(input logic [31:0] addr);
        return (addr == 32'h0000_0010) ? 32'hA5A5_1234 : (addr ^ 32'h1234_0000);
    endfunction

    task automatic check_rsp(input int p, input logic [31:0] data);
        logic [31:0] exp;
        if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp port %0d: got data %h expected no response", p, data);
        end else begin
            exp = (p == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("p%0d_rsp_data", p), data, exp);
            if (timeout_phase == 0) chk($sformatf("p%0d_rsp_latency", p), 32'(rsp_prev), 32'd1);
        end
    endtask

    // Monitor: grant log, DMA run tracking and response scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (p0_ready) gnt_log.push_back(0);
            if (p1_ready) gnt_log.push_back(1);
            if (p1_ready && p0_valid) run_len++;
            else if (p0_ready || !p0_valid) run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (p0_rsp_valid) check_rsp(0, p0_rdata);
            if (p1_rsp_valid) check_rsp(1, p1_rdata);
        end
    end

    // SDRAM controller model.
    initial begin
        bit aborted;
        model_ready = 1'b0;
        model_rsp   = 1'b0;
        model_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_valid && ctrl_en != 0 && rst_n) begin
                cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb;
                for (int k = 0; k < ready_delay; k++) begin
                    @(posedge clk); #1;
                    chk("hold_ctrl", {26'd0, mem_valid, mem_we, mem_wstrb}, {26'd0, 1'b1, cap_we, cap_wstrb});
                    chk("hold_addr", mem_addr, cap_addr);
                    chk("hold_wdata", mem_wdata, cap_wdata);
                end
                model_ready = 1'b1;
                @(posedge clk); #1;
                model_ready = 1'b0;
                in_wait = 1;
                aborted = 0;
                for (int k = 0; k < rsp_delay - 1; k++) begin
                    @(posedge clk); #1;
                    if (!rst_n) aborted = 1;
                end
                if (!aborted && rst_n) begin
                    model_rsp   = 1'b1;
                    model_rdata = cap_we ? 32'hFFFF_FFFF : rdata_for(cap_addr);
                    @(posedge clk); #1;
                    model_rsp   = 1'b0;
                    model_rdata = '0;
                end
                in_wait = 0;
            end
        end
    end

    task automatic req(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
        bit done = 0;
        if (p == 0) begin
            p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_wstrb = strb;
        end else begin
            p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_wstrb = strb;
        end
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if ((p == 0 && p0_ready) || (p == 1 && p1_ready)) done = 1;
        end
        @(posedge clk); #1;
        if (p == 0) p0_valid = 1'b0;
        else        p1_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_grant port %0d addr %h: got no ready expected ready within 300 cycles", p, addr);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d/%0d responses outstanding expected 0", sb0.size(), sb1.size());
            sb0.delete();
            sb1.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, "_rsp_valids"}, {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
        chk({tag, "_p0_rdata"}, p0_rdata, 32'd0);
        chk({tag, "_p1_rdata"}, p1_rdata, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] p1_run_addr[6] = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410, 32'h414};
        int exp_alt[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        rst_n = 1'b0;
        p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
        p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
        stray_ready = 0; stray_rsp = 0;
        repeat (2) @(posedge clk); #1;
        check_outputs_zero("reset");
        chk("reset_ready", {30'd0, p1_ready, p0_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single p0 read: ready in cycle 0, mem_valid in cycle 1.
        rsp_delay = 8;
        sb0.push_back(32'hA5A5_1234);
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0010; p0_wdata = '0; p0_wstrb = 4'hF;
        @(negedge clk);
        chk("t1_p0_ready_c0", 32'(p0_ready), 32'd1);
        chk("t1_p1_ready_c0", 32'(p1_ready), 32'd0);
        @(posedge clk); #1;
        p0_valid = 1'b0;
        chk("t1_mem_valid_c1", 32'(mem_valid), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h0000_0010);
        chk("t1_mem_we", 32'(mem_we), 32'd0);
        drain(100);
        rsp_delay = 3;

        // Both ports continuously valid: strict alternation starting with port 0.
        do_reset();
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            sb0.push_back(32'h1234_0100 + 32'(4 * i));
            sb1.push_back(32'h1234_0200 + 32'(4 * i));
        end
        fork
            for (int i = 0; i < 4; i++) req(0, 1'b0, 32'h100 + 32'(4 * i), 32'd0, 4'hF);
            for (int i = 0; i < 4; i++) req(1, 1'b0, 32'h200 + 32'(4 * i), 32'd0, 4'hF);
        join
        drain(200);
        chk("alt_grant_count", 32'(gnt_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++)
            chk($sformatf("alt_grant_%0d", i), 32'(gnt_log[i]), 32'(exp_alt[i]));

        // Port 1 streaming with intermittent port 0 traffic.
        max_run = 0;
        run_len = 0;
        for (int i = 0; i < 6; i++) sb1.push_back(p1_run_addr[i] ^ 32'h1234_0000);
        sb0.push_back(32'h1234_0500);
        sb0.push_back(32'h1234_0504);
        fork
            for (int i = 0; i < 6; i++) req(1, 1'b0, p1_run_addr[i], 32'd0, 4'hF);
            begin
                repeat (3) @(posedge clk); #1;
                req(0, 1'b0, 32'h500, 32'd0, 4'hF);
                repeat (15) @(posedge clk); #1;
                req(0, 1'b0, 32'h504, 32'd0, 4'hF);
            end
        join
        drain(300);
        chk("max_dma_run_le_4", 32'(max_run <= 4), 32'd1);

        // p1 write with controller stalling ready for 5 cycles.
        ready_delay = 5;
        sb1.push_back(32'h0000_0000);
        req(1, 1'b1, 32'h300, 32'h0000_BEEF, 4'b0011);
        drain(100);
        ready_delay = 0;
        chk("t3_cmd_we", 32'(cap_we), 32'd1);
        chk("t3_cmd_addr", cap_addr, 32'h300);
        chk("t3_cmd_wdata", cap_wdata, 32'h0000_BEEF);
        chk("t3_cmd_wstrb", 32'(cap_wstrb), 32'h3);

        // Reset while in WAIT: response dropped, next request granted normally.
        rsp_delay = 30;
        req(0, 1'b0, 32'h600, 32'd0, 4'hF);
        for (int i = 0; i < 50 && in_wait == 0; i++) @(posedge clk);
        chk("t4_reached_wait", 32'(in_wait), 32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t4_async");
        @(posedge clk); #1;
        stray_rsp = 1'b1;
        @(posedge clk); #1;
        stray_rsp = 1'b0;
        @(negedge clk);
        chk("t4_no_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rsp_delay = 3;
        sb1.push_back(32'h1234_0700);
        req(1, 1'b0, 32'h700, 32'd0, 4'hF);
        drain(100);

        // Stray controller ready in IDLE is ignored.
        stray_ready = 1'b1;
        @(posedge clk); #1;
        stray_ready = 1'b0;
        chk("stray_ready_mem_valid", 32'(mem_valid), 32'd0);
        sb0.push_back(32'h0000_0000);
        req(0, 1'b1, 32'h800, 32'h1122_3344, 4'hF);
        drain(100);

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Controller never answers: watchdog completes with the error word.
        do_reset();
        chk("to_initial", 32'(timeout), 32'd0);
        ctrl_en = 0;
        timeout_phase = 1;
        sb0.push_back(32'hDEAD_BEEF);
        req(0, 1'b0, 32'h900, 32'd0, 4'hF);
        drain(70000);
        timeout_phase = 0;
        chk("to_sticky_set", 32'(timeout), 32'd1);
        ctrl_en = 1;
        sb1.push_back(32'h1234_0A00);
        req(1, 1'b0, 32'hA00, 32'd0, 4'hF);
        drain(100);
        chk("to_sticky_hold", 32'(timeout), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single native port of the SDRAM controller between two requesters: port 0 (CPU bus bridge) and port 1 (SD card DMA engine).
- Sits in the i_sysclk domain between those masters and the SDRAM controller's user interface.
- Allows one outstanding transaction at a time.
- Uses round-robin arbitration with a configurable CPU-latency guarantee.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- MAX_DMA_RUN, 4, maximum back-to-back grants to port 1 while port 0 is requesting.

Ports:
- i_sysclk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pN_valid  in  1  request valid, N=0,1.
- o_pN_ready  out  1  request accepted this cycle.
- i_pN_we  in  1  1=write, 0=read.
- i_pN_addr  in  ADDR_WIDTH  byte address.
- i_pN_wdata  in  DATA_WIDTH  write data.
- i_pN_wstrb  in  DATA_WIDTH/8  byte enables.
- o_pN_rsp_valid  out  1  one-cycle response pulse.
- o_pN_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- o_mem_valid  out  1  command to controller.
- i_mem_ready  in  1  controller accepts command.
- o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb  out  command fields.
- i_mem_rsp_valid  in  1  controller completion; fires for reads and write acks.
- i_mem_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset: all outputs 0; state IDLE; last-grant pointer = port 1, so port 0 wins the first tie; dma_run counter = 0.
- FSM IDLE:
  - If any i_pN_valid, select the winner, pulse o_pN_ready for 1 cycle, latch the request into the command register, go to ISSUE.
  - Ready is combinational on state==IDLE and the winner only.
  - Minimum latency: valid at cycle 0, ready at cycle 0, o_mem_valid at cycle 1.
- FSM ISSUE:
  - o_mem_valid=1 and command fields held stable until i_mem_ready.
  - On i_mem_ready, go to WAIT.
- FSM WAIT:
  - On i_mem_rsp_valid, copy i_mem_rdata to o_pG_rdata and pulse o_pG_rsp_valid of the granted port G for exactly 1 cycle, registered: next cycle after i_mem_rsp_valid.
  - Go to IDLE.
  - Responses for a write carry rdata=0.
- Arbitration:
  - Both valid: grant the port not granted last, except when dma_run==MAX_DMA_RUN, in which case port 0 wins.
  - dma_run increments on each port-1 grant while i_p0_valid=1.
  - dma_run clears on any port-0 grant or when i_p0_valid=0.
  - It saturates at MAX_DMA_RUN.
- i_mem_rsp_valid outside WAIT is ignored; an assertion fires in simulation.
- Stray i_mem_ready outside ISSUE is ignored.
- Requesters must hold valid/fields until ready. An unselected port simply waits and keeps its request.
- Async reset mid-transaction: everything returns to reset values immediately. The in-flight response is dropped; the SDRAM controller is reset by the same net.
- Back-to-back: the earliest next grant is the cycle after rsp_valid is pulsed (IDLE re-entered).

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counts cycles in ISSUE+WAIT.
  - On reaching 16'hFFFF, the FSM returns to IDLE and pulses o_pG_rsp_valid with rdata=32'hDEADBEEF.
  - Sticky output o_timeout (1 bit, reset 0) sets; it is cleared only by reset.
  - A late i_mem_rsp_valid following a timeout is discarded.
- When undefined: no counter, no o_timeout port; the FSM waits indefinitely.

Decomposition:
- Package sdram_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - the request struct typedef (we, addr, wdata, wstrb);
  - the TIMEOUT_VAL and TIMEOUT_DATA constants.
- One sub-module, sdram_arb_rr_pick: a combinational 2-way round-robin picker with the starvation override. Inputs: valids, last_grant, dma_run_full. Output: grant index.

Test Plan:
- Single read on p0 (addr 0x0000_0010, controller returns 0xA5A5_1234 after 8 cycles) -> ready at cycle 0, o_mem_valid at cycle 1; p0 rsp_valid one cycle after i_mem_rsp_valid with rdata 0xA5A5_1234; p1 outputs stay 0.
- Both ports hold valid continuously with MAX_DMA_RUN=4 -> grants alternate 0,1,0,1…; with p0 requesting only intermittently, no run of more than 4 consecutive p1 grants while p0 is pending.
- p1 write (wstrb 4'b0011, data 0x0000_BEEF) with i_mem_ready held low for 5 cycles -> o_mem_* fields stable all 5 cycles; single p1 rsp_valid after the ack.
- Assert i_rst_n=0 while in WAIT -> all outputs 0 immediately; subsequent controller rsp ignored; next request on p1 is granted normally.
- With SDRAM_ARB_TIMEOUT_EN and a controller that never responds -> after 65535 cycles, rsp_valid with 0xDEADBEEF and o_timeout=1; a following request completes normally with o_timeout still 1.
- Stray i_mem_rsp_valid in IDLE -> no rsp_valid on either port; simulation assertion fires.
